// File: rtl/mips_ex_pkg.sv
// Shared constants and types for the execute stage and its multiplier.
package mips_ex_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int TAR_W  = 26;

  // ALUop encodings from the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  // Sequential multiplier states
  typedef enum logic [1:0] {
    M_IDLE = 2'b00,
    M_BUSY = 2'b01,
    M_DONE = 2'b10
  } mult_state_e;

endpackage

// File: rtl/ex_mem_stage_if.sv
// ID/EX inputs, MEM/WB forwarding inputs and EX/MEM outputs of the execute stage.
// Optional macro EX_OVF_TRAP_EN adds the ovf_exc output.
interface ex_mem_stage_if;
  import mips_ex_pkg::*;

  logic [1:0]        WB_in;
  logic [3:0]        MEM_in;
  logic              RegDst;
  logic [1:0]        ALUop;
  logic              ALUSrc;
  logic [DATA_W-1:0] nextAddress_in;
  logic [DATA_W-1:0] A_in;
  logic [DATA_W-1:0] B_in;
  logic [DATA_W-1:0] imm_in;
  logic [REG_W-1:0]  Ins25_in;
  logic [REG_W-1:0]  Ins20_in;
  logic [REG_W-1:0]  Ins15_in;
  logic [TAR_W-1:0]  tar_in;
  logic              memwb_RegWrite;
  logic [REG_W-1:0]  memwb_WriteReg;
  logic [DATA_W-1:0] memwb_data;
  logic              ex_flush;

  logic              stall_req;
  logic [1:0]        WB_out;
  logic [3:0]        MEM_out;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] StoreData;
  logic [REG_W-1:0]  WriteReg;
  logic              Zero;
  logic [DATA_W-1:0] branchTarget;
  logic [DATA_W-1:0] jumpTarget;
`ifdef EX_OVF_TRAP_EN
  logic              ovf_exc;
`endif

  modport slave (
    input  WB_in, MEM_in, RegDst, ALUop, ALUSrc, nextAddress_in, A_in, B_in,
           imm_in, Ins25_in, Ins20_in, Ins15_in, tar_in,
           memwb_RegWrite, memwb_WriteReg, memwb_data, ex_flush,
    output stall_req, WB_out, MEM_out, ALUResult, StoreData, WriteReg, Zero,
           branchTarget, jumpTarget
`ifdef EX_OVF_TRAP_EN
    , output ovf_exc
`endif
  );

  modport master (
    output WB_in, MEM_in, RegDst, ALUop, ALUSrc, nextAddress_in, A_in, B_in,
           imm_in, Ins25_in, Ins20_in, Ins15_in, tar_in,
           memwb_RegWrite, memwb_WriteReg, memwb_data, ex_flush,
    input  stall_req, WB_out, MEM_out, ALUResult, StoreData, WriteReg, Zero,
           branchTarget, jumpTarget
`ifdef EX_OVF_TRAP_EN
    , input ovf_exc
`endif
  );

endinterface

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier owning HI/LO; holds the front end while busy.
module mult_seq
  import mips_ex_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_req,
  input  logic              signed_op,
  input  logic              ex_flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall_req,
  output logic              mult_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W  = $clog2(MULT_CYCLES);
  localparam int PROD_W = 2 * DATA_W;

  mult_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [PROD_W-1:0] mcand_q;
  logic [PROD_W-1:0] acc_q;
  logic [DATA_W-1:0] mplier_q;
  logic              neg_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic [PROD_W-1:0] partial;
  logic [PROD_W-1:0] product;

  // Operand magnitudes, next partial sum and sign-corrected final product
  always_comb begin
    mag_a   = (signed_op && op_a[DATA_W-1]) ? (~op_a + DATA_W'(1)) : op_a;
    mag_b   = (signed_op && op_b[DATA_W-1]) ? (~op_b + DATA_W'(1)) : op_b;
    partial = acc_q + (mplier_q[0] ? mcand_q : '0);
    product = neg_q ? (~partial + PROD_W'(1)) : partial;
  end

  // Stall is combinational so the issuing cycle already holds the front end;
  // a flush releases it in the same cycle, and reset forces it low.
  assign stall_req = reset && !ex_flush &&
                     (((state_q == M_IDLE) && mult_req) || (state_q == M_BUSY));
  assign mult_done = (state_q == M_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Multiplier FSM: latch operands, iterate shift-add, commit product to HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= M_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        M_IDLE: begin
          if (mult_req && !ex_flush) begin
            mcand_q  <= {{DATA_W{1'b0}}, mag_a};
            mplier_q <= mag_b;
            acc_q    <= '0;
            neg_q    <= signed_op && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
            cnt_q    <= '0;
            state_q  <= M_BUSY;
          end
        end
        M_BUSY: begin
          if (ex_flush) begin
            state_q <= M_IDLE;
          end else begin
            acc_q    <= partial;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(MULT_CYCLES - 1)) begin
              {hi_q, lo_q} <= product;
              state_q      <= M_DONE;
            end
          end
        end
        M_DONE:  state_q <= M_IDLE;
        default: state_q <= M_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: forwarding, ALU, destination
// select, branch/jump targets and the sequential multiplier.
// Optional macro EX_OVF_TRAP_EN: signed add/sub overflow suppresses RegWrite
// and raises the registered ovf_exc output.
module ex_mem_stage
  import mips_ex_pkg::*;
#(
  parameter int MULT_CYCLES = 32
) (
  input logic           clk,
  input logic           reset,
  ex_mem_stage_if.slave bus
);

  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] alu_res;
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] rt_s;
  logic              mult_req;
  logic              signed_op;
  logic              stall_req;
  logic              mult_done;
  logic              bubble;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  logic [1:0]        wb_d,    wb_q;
  logic [3:0]        mem_d,   mem_q;
  logic [DATA_W-1:0] alu_d,   alu_q;
  logic [DATA_W-1:0] store_d, store_q;
  logic [REG_W-1:0]  wreg_d,  wreg_q;
  logic              zero_d,  zero_q;
  logic [DATA_W-1:0] btar_d,  btar_q;
  logic [DATA_W-1:0] jtar_d,  jtar_q;
`ifdef EX_OVF_TRAP_EN
  logic              ovf;
  logic              ovf_d,   ovf_q;
`endif

  assign funct = bus.imm_in[5:0];
  assign shamt = bus.imm_in[10:6];

  // Forwarding: EX/MEM result beats MEM/WB data; register 0 never forwards
  always_comb begin
    fwd_a = bus.A_in;
    if (wb_q[1] && (wreg_q != '0) && (wreg_q == bus.Ins25_in))
      fwd_a = alu_q;
    else if (bus.memwb_RegWrite && (bus.memwb_WriteReg != '0) &&
             (bus.memwb_WriteReg == bus.Ins25_in))
      fwd_a = bus.memwb_data;

    fwd_b = bus.B_in;
    if (wb_q[1] && (wreg_q != '0) && (wreg_q == bus.Ins20_in))
      fwd_b = alu_q;
    else if (bus.memwb_RegWrite && (bus.memwb_WriteReg != '0) &&
             (bus.memwb_WriteReg == bus.Ins20_in))
      fwd_b = bus.memwb_data;
  end

  assign op_b = bus.ALUSrc ? bus.imm_in : fwd_b;
  assign sum  = fwd_a + op_b;
  assign diff = fwd_a - op_b;
  assign a_s  = fwd_a;
  assign b_s  = op_b;
  assign rt_s = fwd_b;

  assign mult_req  = (bus.ALUop == ALUOP_RTYPE) &&
                     ((funct == FN_MULT) || (funct == FN_MULTU));
  assign signed_op = (funct == FN_MULT);

  // ALU control decode and ALU; shifts act on the forwarded rt value
  always_comb begin
    alu_res = '0;
    case (bus.ALUop)
      ALUOP_ADD: alu_res = sum;
      ALUOP_SUB: alu_res = diff;
      ALUOP_OR:  alu_res = fwd_a | {16'h0000, bus.imm_in[15:0]};
      default: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_res = sum;
          FN_SUB, FN_SUBU: alu_res = diff;
          FN_AND:  alu_res = fwd_a & op_b;
          FN_OR:   alu_res = fwd_a | op_b;
          FN_XOR:  alu_res = fwd_a ^ op_b;
          FN_NOR:  alu_res = ~(fwd_a | op_b);
          FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
          FN_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (fwd_a < op_b)};
          FN_SLL:  alu_res = fwd_b << shamt;
          FN_SRL:  alu_res = fwd_b >> shamt;
          FN_SRA:  alu_res = $unsigned(rt_s >>> shamt);
          FN_MFHI: alu_res = hi;
          FN_MFLO: alu_res = lo;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  // Signed overflow for add-class and sub operations
  always_comb begin
    ovf = 1'b0;
    if ((bus.ALUop == ALUOP_ADD) ||
        ((bus.ALUop == ALUOP_RTYPE) && (funct == FN_ADD)))
      ovf = (fwd_a[DATA_W-1] == op_b[DATA_W-1]) &&
            (sum[DATA_W-1] != fwd_a[DATA_W-1]);
    else if ((bus.ALUop == ALUOP_RTYPE) && (funct == FN_SUB))
      ovf = (fwd_a[DATA_W-1] != op_b[DATA_W-1]) &&
            (diff[DATA_W-1] != fwd_a[DATA_W-1]);
  end
`endif

  mult_seq #(.MULT_CYCLES(MULT_CYCLES)) u_mult (
    .clk       (clk),
    .reset     (reset),
    .mult_req  (mult_req),
    .signed_op (signed_op),
    .ex_flush  (bus.ex_flush),
    .op_a      (fwd_a),
    .op_b      (fwd_b),
    .stall_req (stall_req),
    .mult_done (mult_done),
    .hi        (hi),
    .lo        (lo)
  );

  // A mult in its DONE cycle retires as a bubble, as does anything stalled or flushed
  assign bubble = bus.ex_flush || stall_req || mult_done;

  // Next EX/MEM register contents
  always_comb begin
    wb_d    = bus.WB_in;
    mem_d   = bus.MEM_in;
    alu_d   = alu_res;
    store_d = fwd_b;
    wreg_d  = bus.RegDst ? bus.Ins15_in : bus.Ins20_in;
    zero_d  = (alu_res == '0);
    btar_d  = bus.nextAddress_in + {bus.imm_in[DATA_W-3:0], 2'b00};
    jtar_d  = {bus.nextAddress_in[DATA_W-1:DATA_W-4], bus.tar_in, 2'b00};
`ifdef EX_OVF_TRAP_EN
    ovf_d   = ovf;
    if (ovf) wb_d[1] = 1'b0;
`endif
    if (bubble) begin
      wb_d    = '0;
      mem_d   = '0;
      alu_d   = '0;
      store_d = '0;
      wreg_d  = '0;
      zero_d  = 1'b0;
      btar_d  = '0;
      jtar_d  = '0;
`ifdef EX_OVF_TRAP_EN
      ovf_d   = 1'b0;
`endif
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q    <= '0;
      mem_q   <= '0;
      alu_q   <= '0;
      store_q <= '0;
      wreg_q  <= '0;
      zero_q  <= 1'b0;
      btar_q  <= '0;
      jtar_q  <= '0;
`ifdef EX_OVF_TRAP_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      wb_q    <= wb_d;
      mem_q   <= mem_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      wreg_q  <= wreg_d;
      zero_q  <= zero_d;
      btar_q  <= btar_d;
      jtar_q  <= jtar_d;
`ifdef EX_OVF_TRAP_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.stall_req    = stall_req;
  assign bus.WB_out       = wb_q;
  assign bus.MEM_out      = mem_q;
  assign bus.ALUResult    = alu_q;
  assign bus.StoreData    = store_q;
  assign bus.WriteReg     = wreg_q;
  assign bus.Zero         = zero_q;
  assign bus.branchTarget = btar_q;
  assign bus.jumpTarget   = jtar_q;
`ifdef EX_OVF_TRAP_EN
  assign bus.ovf_exc      = ovf_q;
`endif

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register. Consumes the ID/EX register outputs; produces registered EX/MEM values for the memory stage.
- Contains:
  - forwarding muxes
  - ALU control decode and ALU
  - destination-register select
  - branch and jump target generation
  - sequential 32-cycle multiplier with HI/LO registers, which stalls the front end while busy

Parameters:
- MULT_CYCLES, 32, iterations of the shift-add multiplier (must equal data width).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- WB_in  in  2  {RegWrite, MemtoReg} from ID/EX
- MEM_in  in  4  {Branch, MemRead, MemWrite, Jump} from ID/EX
- RegDst  in  1  1 selects Ins15 (rd) as destination; 0 selects Ins20 (rt)
- ALUop  in  2  00 add, 01 sub, 10 R-type (funct), 11 or
- ALUSrc  in  1  1 selects imm as operand B
- nextAddress_in  in  32  PC+4
- A_in  in  32  rs read data
- B_in  in  32  rt read data
- imm_in  in  32  sign-extended immediate; [5:0] funct, [10:6] shamt
- Ins25_in  in  5  rs
- Ins20_in  in  5  rt
- Ins15_in  in  5  rd
- tar_in  in  26  jump target field
- memwb_RegWrite  in  1  MEM/WB write enable, for forwarding
- memwb_WriteReg  in  5  MEM/WB destination register
- memwb_data  in  32  MEM/WB writeback value
- ex_flush  in  1  squash the instruction currently in EX
- stall_req  out  1  holds PC, IF/ID and ID/EX
- WB_out  out  2  registered WB controls
- MEM_out  out  4  registered MEM controls
- ALUResult  out  32  registered ALU/HI/LO result
- StoreData  out  32  registered forwarded rt value
- WriteReg  out  5  registered destination register
- Zero  out  1  registered (ALU result == 0)
- branchTarget  out  32  registered nextAddress + (imm<<2)
- jumpTarget  out  32  registered {nextAddress[31:28], tar, 2'b00}

Behaviour:
- Reset (reset=0, async):
  - all outputs 0; stall_req 0
  - multiplier FSM in IDLE
  - HI=LO=0
- Forwarding, per operand, applied to rs and rt before the ALUSrc mux:
  - 1st priority: EX/MEM (WB_out[1] && WriteReg!=0 && WriteReg==src) uses ALUResult.
  - 2nd priority: MEM/WB (memwb_RegWrite && memwb_WriteReg!=0 && match) uses memwb_data.
  - Otherwise the register value is used.
  - Load-use stalls are handled by the upstream hazard unit, not here.
- ALU funct codes (ALUop=10):
  - add 100000, addu 100001, sub 100010, subu 100011 (all wrap, no trap)
  - and 100100, or 100101, xor 100110, nor 100111
  - slt 101010 (signed), sltu 101011
  - sll 000000, srl 000010, sra 000011 (shift forwarded rt by shamt)
  - mfhi 010000, mflo 010010
  - mult 011000, multu 011001
  - any other funct gives result 0.
- ALUop=11: result = A | zero-extended imm[15:0].
- Pipeline register timing:
  - Updates every edge; latency 1 cycle.
  - When ex_flush=1 or stall_req=1 at an edge, it loads a bubble: WB_out=0, MEM_out=0, other fields don't-care but are driven 0.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE:
    - If the EX instruction is mult/multu and ex_flush=0: stall_req=1 combinationally.
    - At the edge, latch magnitudes (mult) or raw operands (multu) plus the sign, clear the counter, and go to BUSY.
  - BUSY:
    - stall_req=1.
    - One shift-add per cycle.
    - At counter==MULT_CYCLES-1: write the 64-bit product (negated if the signs differ for mult) into {HI,LO} and go to DONE.
  - DONE:
    - stall_req=0, so ID/EX advances.
    - The mult retires as a bubble (WB forced 0).
    - Next state is IDLE; a mult still present in DONE is never restarted.
  - A mult therefore occupies EX for MULT_CYCLES+2 cycles (34).
  - mfhi/mflo immediately after a mult read the new value.
  - ex_flush in BUSY or DONE: abort to IDLE, HI/LO unchanged, stall_req drops that cycle.
- Simultaneous flush and mult issue: flush wins, and the mult is not started.

Optional Feature:
- Macro EX_OVF_TRAP_EN.
- When defined:
  - Signed overflow on add/sub, or on ALUop=00 with opcode treated signed, forces WB_out[1]=0 in the registered output.
  - A registered output port ovf_exc (1 bit) is added; it is 1 for exactly that instruction's EX/MEM cycle.
- When undefined: no port, and overflow is ignored (wrap).

Decomposition:
- Package mips_ex_pkg:
  - ALUop encodings
  - funct localparams
  - mult FSM state typedef (IDLE/BUSY/DONE)
  - width constants
- One sub-module, mult_seq: FSM, counter, operand/product registers, HI/LO, stall_req generation.

Test Plan:
- ALUop=10, funct 100010, A=5, B=7 -> next cycle ALUResult=0xFFFFFFFE, Zero=0; ALUSrc=1, ALUop=00, A=0x10, imm=0xFFFFFFFC -> ALUResult=0x0C.
- Back-to-back dependency: prev WriteReg=8 result 0x55, current rs=8, MEM/WB also rd=8 with 0x99 -> EX/MEM value 0x55 used.
- mult A=-3, B=7 -> stall_req high exactly 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB; following mflo -> ALUResult=0xFFFFFFEB.
- multu A=0xFFFFFFFF, B=2 -> HI=1, LO=0xFFFFFFFE; ex_flush asserted during BUSY cycle 10 -> stall_req drops, HI/LO keep the old values.
- Branch nextAddress=0x100, imm=0xFFFFFFFF, Branch set -> branchTarget=0xFC, MEM_out=4'b1000; ex_flush same cycle -> MEM_out=0, WB_out=0.
- reset pulsed low mid-BUSY -> all outputs 0 immediately (asynchronous), HI=LO=0, stall_req=0.
